m_16to1_serializer: RTL and testbench
=====================================

M_16TO1_SERIALIZER -- requirements
Module: m_16to1_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 3, meaning bits per key element.
REQ-002 SHALL have parameter N, default 16, meaning number of elements in the sorted input vector.
REQ-003 SHALL have port clk  input  1  meaning the single clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  meaning a sorted vector is offered.
REQ-006 SHALL have port in_ready  output  1  meaning the block can capture a vector this cycle.
REQ-007 SHALL have port in_data  input  N*WIDTH  meaning the sorted vector; element k is in_data[(k+1)*WIDTH-1:k*WIDTH], k=0 smallest.
REQ-008 SHALL have port in_desc  input  1  meaning emit order: 0 ascending from k=0, 1 descending from k=N-1.
REQ-009 SHALL have port in_count  input  5  meaning elements to emit, 1..N; value 0 or a value above N means N.
REQ-010 SHALL have port flush  input  1  meaning synchronous abort of the current stream.
REQ-011 SHALL have port out_valid  output  1  meaning out_data holds a valid element.
REQ-012 SHALL have port out_ready  input  1  meaning the downstream consumer accepts the element.
REQ-013 SHALL have port out_data  output  WIDTH  meaning the current element.
REQ-014 SHALL have port out_idx  output  4  meaning the ordinal of the current beat within the stream, starting at 0.
REQ-015 SHALL have port out_last  output  1  meaning the current beat is the final beat of the stream.
REQ-016 SHALL have port busy  output  1  meaning the FSM is in STREAM.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and STREAM.
REQ-018 in_ready SHALL equal (IDLE) OR (STREAM AND out_last AND out_ready AND NOT flush).
REQ-019 A capture SHALL occur on in_valid AND in_ready AND NOT flush; it latches in_data, in_desc and the resolved count, clears the beat counter, and enters or stays in STREAM.
REQ-020 out_valid SHALL be asserted in STREAM only; the first beat SHALL appear exactly one cycle after capture.
REQ-021 For beat counter b, out_data SHALL be element b when ascending and element N-1-b when descending, taken from the latched vector.
REQ-022 A beat transfers on out_valid AND out_ready; b then increments by 1.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL remain stable.
REQ-024 out_last SHALL be 1 when b equals latched count-1; with count=1 the first beat is also the last.
REQ-025 After the last beat transfers with no simultaneous capture, the FSM SHALL return to IDLE and out_valid SHALL be 0 the next cycle.
REQ-026 A last-beat transfer coinciding with a capture SHALL start the new stream with no idle cycle (back-to-back).
REQ-027 flush=1 SHALL force IDLE on the next edge, drop any unsent beats, and block capture in the same cycle; flush in IDLE has no effect.
REQ-028 in_data changes while in STREAM SHALL NOT affect emitted values.
REQ-029 out_idx SHALL equal b, which never wraps because b never exceeds count-1.

Reset
REQ-030 rst_n=0 SHALL asynchronously force IDLE, b=0, latched vector=0, latched count=N, latched desc=0.
REQ-031 During and after reset: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, and in_ready=1 once rst_n deasserts.
REQ-032 A reset asserted mid-stream SHALL discard the stream; no beat is emitted after rst_n deasserts until a new capture.

Structure
REQ-033 Package sorter_pkg SHALL hold the defaults WIDTH=3 and N=16, the beat-counter width constant and the FSM state type, shared with the sorter network blocks.
REQ-034 A single sub-module m_elem_sel SHALL implement the N-to-1 element multiplexer, including the descending index mirror; the FSM, counter and registers stay in the top module.

Verification
REQ-035 Ascending full stream: in_data elements 0..15 = {0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7}, in_desc=0, in_count=0, out_ready=1 -> 16 beats in 16 consecutive cycles starting one cycle after capture, data in that order, out_last on beat 15 only.
REQ-036 Descending top-3: same vector, in_desc=1, in_count=3 -> beats 7,7,6 with out_idx 0,1,2, out_last on idx 2, then IDLE.
REQ-037 Backpressure: out_ready toggled 1,0,0,1 -> data, out_idx and out_last held during stall cycles, no beat lost or duplicated.
REQ-038 Back-to-back: second vector with in_valid held high during the last beat, count=1 -> next stream's single beat follows with no gap, out_last=1.
REQ-039 Flush at beat 5 with in_valid=1 the same cycle -> no capture, out_valid=0 next cycle, in_ready=1 the cycle after.
REQ-040 rst_n pulsed low at beat 8 -> all outputs 0 immediately; no out_valid after release until a new capture.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared definitions for the sorter network blocks and the output serializer.
//   WIDTH_DEF / N_DEF : default key width and element count
//   BEAT_W            : beat counter width (indexes 0..N_DEF-1)
//   CNT_W             : width of a resolved element count (holds 1..N_DEF)
//   state_t           : serializer FSM state type
//   resolve_count()   : maps a requested count onto 1..n (0 or >n means n)
package sorter_pkg;

  localparam int unsigned WIDTH_DEF = 3;
  localparam int unsigned N_DEF     = 16;
  localparam int unsigned BEAT_W    = $clog2(N_DEF);
  localparam int unsigned CNT_W     = BEAT_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] resolve_count(input logic [4:0] req,
                                                      input int unsigned n);
    logic [CNT_W-1:0] res;
    if ((req == 5'd0) || (int'(req) > int'(n))) begin
      res = CNT_W'(n);
    end else begin
      res = CNT_W'(req);
    end
    return res;
  endfunction

endpackage

// File: rtl/m_elem_sel.sv
// N-to-1 element multiplexer for the serializer.
//   vec_i  : packed vector, element k at [(k+1)*WIDTH-1 : k*WIDTH]
//   idx_i  : beat index b
//   desc_i : 0 selects element b, 1 selects element N-1-b
//   elem_o : selected element
module m_elem_sel
  import sorter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned N     = N_DEF
) (
  input  logic [N*WIDTH-1:0] vec_i,
  input  logic [BEAT_W-1:0]  idx_i,
  input  logic               desc_i,
  output logic [WIDTH-1:0]   elem_o
);

  logic [BEAT_W-1:0] sel_s;

  // Mirror the index for descending order, then pick the element.
  always_comb begin
    sel_s  = idx_i;
    elem_o = {WIDTH{1'b0}};
    if (desc_i) begin
      sel_s = BEAT_W'(N - 1) - idx_i;
    end else begin
      sel_s = idx_i;
    end
    elem_o = vec_i[int'(sel_s)*int'(WIDTH) +: WIDTH];
  end

endmodule

// File: rtl/m_16to1_serializer.sv
// Serializes a latched sorted vector into a ready/valid stream of elements.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   : vector handshake; in_data, in_desc, in_count captured
//   flush               : synchronous abort of the current stream
//   out_valid/out_ready : element handshake; out_data, out_idx, out_last per beat
//   busy                : FSM is streaming
module m_16to1_serializer
  import sorter_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned N     = N_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic               in_desc,
  input  logic [4:0]         in_count,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [3:0]         out_idx,
  output logic               out_last,
  output logic               busy
);

  state_t               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q,  beat_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [N*WIDTH-1:0]   vec_q,   vec_d;
  logic                 desc_q,  desc_d;

  logic                 streaming_s;
  logic                 is_last_s;
  logic                 capture_s;
  logic                 transfer_s;
  logic [WIDTH-1:0]     elem_s;

  m_elem_sel #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_elem_sel (
    .vec_i  (vec_q),
    .idx_i  (beat_q),
    .desc_i (desc_q),
    .elem_o (elem_s)
  );

  // Handshake decode; a new vector may be accepted while the last beat leaves.
  always_comb begin
    streaming_s = (state_q == ST_STREAM);
    is_last_s   = streaming_s && ({1'b0, beat_q} == (cnt_q - CNT_W'(1)));
    transfer_s  = streaming_s && out_ready;
    in_ready    = (state_q == ST_IDLE) ||
                  (is_last_s && out_ready && !flush);
    capture_s   = in_valid && in_ready && !flush;
  end

  // Next-state: flush beats capture beats beat advance.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    desc_d  = desc_q;
    if (flush) begin
      state_d = ST_IDLE;
      beat_d  = {BEAT_W{1'b0}};
    end else if (capture_s) begin
      state_d = ST_STREAM;
      beat_d  = {BEAT_W{1'b0}};
      cnt_d   = resolve_count(in_count, N);
      vec_d   = in_data;
      desc_d  = in_desc;
    end else if (transfer_s) begin
      if (is_last_s) begin
        // Clear rather than increment so b never passes count-1.
        state_d = ST_IDLE;
        beat_d  = {BEAT_W{1'b0}};
      end else begin
        beat_d  = beat_q + BEAT_W'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= {BEAT_W{1'b0}};
      cnt_q   <= CNT_W'(N);
      vec_q   <= {(N*WIDTH){1'b0}};
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      desc_q  <= desc_d;
    end
  end

  // Outputs are pure decodes of registered state; data is zero outside a stream.
  always_comb begin
    out_valid = streaming_s;
    busy      = streaming_s;
    out_last  = is_last_s;
    out_idx   = 4'(beat_q);
    if (streaming_s) begin
      out_data = elem_s;
    end else begin
      out_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_m_16to1_serializer.sv
module tb_m_16to1_serializer;

  localparam int W = 3;
  localparam int N = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_desc;
  logic [4:0]     in_count;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [3:0]     out_idx;
  logic           out_last;
  logic           busy;

  int n_cmp;
  int n_err;

  logic [N*W-1:0] vec_a;

  m_16to1_serializer #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .in_count  (in_count),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int d, input int idx, input bit last);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".idx"},   32'(out_idx),   32'(idx));
    chk({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  // Offer one vector for a single cycle (capture expected from IDLE).
  task automatic offer(input bit desc, input logic [4:0] cnt);
    in_valid = 1'b1;
    in_data  = vec_a;
    in_desc  = desc;
    in_count = cnt;
    @(negedge clk);
    chk("offer.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = {(N*W){1'b1}};
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int k = 0; k < N; k++) vec_a[k*W +: W] = W'(k / 2);

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_desc = 1'b0;
    in_count = 5'd0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.out_idx",   32'(out_idx),   32'd0);
    chk("rst.out_last",  32'(out_last),  32'd0);
    chk("rst.busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Ascending full stream, in_data scrambled after capture
    offer(1'b0, 5'd0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk_beat($sformatf("asc%0d", i), i / 2, i, (i == N - 1));
      tick();
    end
    @(negedge clk);
    chk("asc.end_valid", 32'(out_valid), 32'd0);
    chk("asc.end_busy",  32'(busy),      32'd0);
    tick();

    // Descending top-3
    offer(1'b1, 5'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_beat($sformatf("desc%0d", i), (N - 1 - i) / 2, i, (i == 2));
      tick();
    end
    @(negedge clk);
    chk("desc.end_valid", 32'(out_valid), 32'd0);
    tick();

    // Backpressure: ready pattern 1,0,0,1 then 1; count 4, ascending
    offer(1'b0, 5'd4);
    begin
      int e;
      bit rdy_pat[8];
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      e = 0;
      for (int c = 0; c < 8 && e < 4; c++) begin
        out_ready = rdy_pat[c];
        @(negedge clk);
        chk_beat($sformatf("bp%0d", c), e / 2, e, (e == 3));
        if (rdy_pat[c]) e = e + 1;
        tick();
      end
      out_ready = 1'b1;
      chk("bp.beats", 32'(e), 32'd4);
      @(negedge clk);
      chk("bp.end_valid", 32'(out_valid), 32'd0);
      tick();
    end

    // Back-to-back: count 2 stream, then count-1 descending during last beat
    offer(1'b0, 5'd2);
    @(negedge clk);
    chk_beat("b2b.0", 0, 0, 1'b0);
    tick();
    in_valid = 1'b1; in_data = vec_a; in_desc = 1'b1; in_count = 5'd1;
    @(negedge clk);
    chk_beat("b2b.1", 0, 1, 1'b1);
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0; in_data = {(N*W){1'b1}};
    @(negedge clk);
    chk_beat("b2b.new", 7, 0, 1'b1);
    tick();
    @(negedge clk);
    chk("b2b.end_valid", 32'(out_valid), 32'd0);
    tick();

    // Flush at beat 5 with in_valid high
    offer(1'b0, 5'd0);
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1; in_valid = 1'b1; in_data = vec_a;
    @(negedge clk);
    chk("flush.idx",      32'(out_idx),  32'd5);
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush.valid_after", 32'(out_valid), 32'd0);
    chk("flush.busy_after",  32'(busy),      32'd0);
    chk("flush.in_ready_after", 32'(in_ready), 32'd1);
    tick();

    // Reset pulse at beat 8
    offer(1'b0, 5'd0);
    for (int i = 0; i < 8; i++) tick();
    @(negedge clk);
    chk("rstm.idx_before", 32'(out_idx), 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstm.out_valid", 32'(out_valid), 32'd0);
    chk("rstm.out_data",  32'(out_data),  32'd0);
    chk("rstm.out_idx",   32'(out_idx),   32'd0);
    chk("rstm.out_last",  32'(out_last),  32'd0);
    chk("rstm.busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rstm.idle%0d", i), 32'(out_valid), 32'd0);
    end
    tick();
    offer(1'b1, 5'd1);
    @(negedge clk);
    chk_beat("rstm.new", 7, 0, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
